// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit direction counters, looked up in IF and trained from EX
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_if_pc,
    output logic        o_pc_sel_BTB,
    output logic [31:0] o_pc_BTB,
    input  logic        i_ex_update_en,
    input  logic [31:0] i_ex_pc,
    input  logic [6:0]  i_ex_opcode,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW = 30 - IDX;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic          valid  [ENTRIES];
    logic          jump   [ENTRIES];
    logic [1:0]    ctr    [ENTRIES];
    logic [TW-1:0] tags   [ENTRIES];
    logic [31:0]   target [ENTRIES];

    logic [IDX-1:0] if_idx, ex_idx;
    logic [TW-1:0]  if_tag, ex_tag;
    logic           if_hit, ex_hit, ex_jump, train;
    logic [1:0]     ctr_inc, ctr_dec;
    logic           unused_pc_bits;

    assign if_idx = i_if_pc[IDX+1:2];
    assign if_tag = i_if_pc[31:IDX+2];
    assign ex_idx = i_ex_pc[IDX+1:2];
    assign ex_tag = i_ex_pc[31:IDX+2];
    assign unused_pc_bits = ^{i_if_pc[1:0], i_ex_pc[1:0]};

    // Fetch-side lookup; not-taken hits still expose the stored target
    always_comb begin
        if_hit = valid[if_idx] && tags[if_idx] == if_tag;
        o_pc_sel_BTB = if_hit && (jump[if_idx] || ctr[if_idx][1]);
        o_pc_BTB = if_hit ? target[if_idx] : 32'b0;
    end

    // EX-side decode of whether and how the table is trained this cycle
    always_comb begin
        ex_hit = valid[ex_idx] && tags[ex_idx] == ex_tag;
        ex_jump = i_ex_opcode != OP_B;
        train = i_ex_update_en && (i_ex_opcode == OP_B || i_ex_opcode == OP_JAL || i_ex_opcode == OP_JALR);
        ctr_inc = ctr[ex_idx] == 2'b11 ? 2'b11 : ctr[ex_idx] + 2'd1;
        ctr_dec = ctr[ex_idx] == 2'b00 ? 2'b00 : ctr[ex_idx] - 2'd1;
    end

    // Table state: reset wins, hits retrain, taken misses allocate over any occupant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                jump[i] <= 1'b0;
                ctr[i] <= 2'b01;
                tags[i] <= '0;
                target[i] <= 32'b0;
            end
        end else if (train) begin
            if (ex_hit) begin
                ctr[ex_idx] <= i_ex_taken ? ctr_inc : ctr_dec;
                jump[ex_idx] <= ex_jump;
                if (i_ex_taken) target[ex_idx] <= i_ex_target;
            end else if (i_ex_taken) begin
                valid[ex_idx] <= 1'b1;
                jump[ex_idx] <= ex_jump;
                ctr[ex_idx] <= ex_jump ? 2'b11 : 2'b10;
                tags[ex_idx] <= ex_tag;
                target[ex_idx] <= i_ex_target;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed plan plus randomized traffic checked against a behavioural BTB model
module tb_branch_target_buffer;
    localparam int N = 16;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_R = 7'b0110011;

    logic        i_clk = 0;
    logic        i_rst = 0;
    logic [31:0] i_if_pc = 0;
    logic        o_pc_sel_BTB;
    logic [31:0] o_pc_BTB;
    logic        i_ex_update_en = 0;
    logic [31:0] i_ex_pc = 0;
    logic [6:0]  i_ex_opcode = 0;
    logic        i_ex_taken = 0;
    logic [31:0] i_ex_target = 0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    branch_target_buffer #(.ENTRIES(N)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_if_pc(i_if_pc),
        .o_pc_sel_BTB(o_pc_sel_BTB), .o_pc_BTB(o_pc_BTB),
        .i_ex_update_en(i_ex_update_en), .i_ex_pc(i_ex_pc), .i_ex_opcode(i_ex_opcode),
        .i_ex_taken(i_ex_taken), .i_ex_target(i_ex_target)
    );

    always #5 i_clk = ~i_clk;

    // Model: each slot remembers the word address of the branch that owns it
    bit          m_v [N];
    bit          m_j [N];
    int          m_c [N];
    logic [31:0] m_pc[N];
    logic [31:0] m_t [N];

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit owns(input logic [31:0] pc);
        int k = slot(pc);
        return m_v[k] && (m_pc[k] >> 2) == (pc >> 2);
    endfunction

    always @(posedge i_clk) begin
        int k;
        bit jmp;
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                m_v[i] = 0; m_j[i] = 0; m_c[i] = 1; m_t[i] = 0; m_pc[i] = 0;
            end
        end else if (i_ex_update_en && (i_ex_opcode == OP_B || i_ex_opcode == OP_JAL || i_ex_opcode == OP_JALR)) begin
            k = slot(i_ex_pc);
            jmp = i_ex_opcode != OP_B;
            if (owns(i_ex_pc)) begin
                m_c[k] = i_ex_taken ? (m_c[k] < 3 ? m_c[k] + 1 : 3) : (m_c[k] > 0 ? m_c[k] - 1 : 0);
                if (i_ex_taken) m_t[k] = i_ex_target;
                m_j[k] = jmp;
            end else if (i_ex_taken) begin
                m_v[k] = 1; m_pc[k] = i_ex_pc; m_t[k] = i_ex_target; m_j[k] = jmp; m_c[k] = jmp ? 3 : 2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge i_clk) begin
        int k;
        bit hit;
        if (chk_en) begin
            k = slot(i_if_pc);
            hit = owns(i_if_pc);
            chk("model_sel", {31'b0, o_pc_sel_BTB}, {31'b0, hit && (m_j[k] || m_c[k] >= 2)});
            chk("model_tgt", o_pc_BTB, hit ? m_t[k] : 32'b0);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [6:0] op, input bit tk, input logic [31:0] tgt);
        i_ex_update_en = 1; i_ex_pc = pc; i_ex_opcode = op; i_ex_taken = tk; i_ex_target = tgt;
        tick();
        i_ex_update_en = 0;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input bit sel, input logic [31:0] tgt);
        i_if_pc = pc;
        @(negedge i_clk);
        chk({name, "_sel"}, {31'b0, o_pc_sel_BTB}, {31'b0, sel});
        chk({name, "_tgt"}, o_pc_BTB, tgt);
        tick();
    endtask

    initial begin
        tick();
        i_rst = 1;
        tick();
        tick();
        i_rst = 0;
        chk_en = 1;
        for (int a = 0; a <= 'h3C; a += 4) look("reset_sweep", a, 0, 0);

        upd('h100, OP_B, 1, 'h80);
        look("alloc_hit", 'h100, 1, 'h80);
        look("alloc_alias", 'h140, 0, 0);

        upd('h100, OP_B, 0, 0);
        chk("ctr_weak_nt", m_c[0], 1);
        look("hyst_nt1", 'h100, 0, 'h80);
        upd('h100, OP_B, 0, 0);
        upd('h100, OP_B, 0, 0);
        chk("ctr_sat0", m_c[0], 0);
        upd('h100, OP_B, 1, 'h80);
        chk("ctr_up1", m_c[0], 1);
        look("hyst_t1", 'h100, 0, 'h80);
        upd('h100, OP_B, 1, 'h80);
        upd('h100, OP_B, 1, 'h80);
        chk("ctr_sat3", m_c[0], 3);
        look("hyst_back", 'h100, 1, 'h80);

        upd('h200, OP_JAL, 1, 'h400);
        look("jal", 'h200, 1, 'h400);
        upd('h200, OP_JALR, 1, 'h480);
        look("jalr_retarget", 'h200, 1, 'h480);

        upd('h300, OP_B, 0, 'h10);
        look("nt_miss", 'h300, 0, 0);
        look("nt_keep", 'h200, 1, 'h480);
        i_ex_pc = 'h304; i_ex_opcode = OP_B; i_ex_taken = 1; i_ex_target = 'h44;
        tick();
        look("gate_en", 'h304, 0, 0);
        upd('h304, OP_R, 1, 'h44);
        look("gate_op", 'h304, 0, 0);

        i_if_pc = 'h500;
        i_ex_update_en = 1; i_ex_pc = 'h500; i_ex_opcode = OP_B; i_ex_taken = 1; i_ex_target = 'h600;
        @(negedge i_clk);
        chk("same_cycle_sel", {31'b0, o_pc_sel_BTB}, 32'd0);
        chk("same_cycle_tgt", o_pc_BTB, 32'd0);
        tick();
        i_ex_update_en = 0;
        look("next_cycle", 'h500, 1, 'h600);

        for (int a = 'h10; a <= 'h1C; a += 4) upd(a, OP_JAL, 1, a + 'h1000);
        look("trained", 'h14, 1, 'h1014);
        i_rst = 1;
        upd('h20, OP_JAL, 1, 'h2000);
        i_rst = 0;
        for (int a = 'h10; a <= 'h20; a += 4) look("post_reset", a, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            logic [6:0] ops [4];
            ops[0] = OP_B; ops[1] = OP_JAL; ops[2] = OP_JALR; ops[3] = OP_R;
            i_rst = $urandom_range(0, 299) == 0;
            i_if_pc = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            i_ex_update_en = $urandom_range(0, 3) != 0;
            i_ex_pc = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            i_ex_opcode = ops[$urandom_range(0, 3)];
            i_ex_taken = $urandom_range(0, 1);
            i_ex_target = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        i_rst = 0;
        i_ex_update_en = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
